// File: rtl/pn_gen.sv
// Fibonacci-style PN/LFSR generator with seed load, period measurement and zero-seed lockup guard.
// One step per cycle when run|step; outputs are registered and update on the advancing edge; no backpressure.
module pn_gen #(
  parameter int            N            = 6,
  parameter logic [N-1:0]  TAPS         = 6'b110000,
  parameter logic [N-1:0]  DEFAULT_SEED = {{(N-1){1'b0}}, 1'b1},
  parameter int            CW           = 16
) (
  input  logic          clock,
  input  logic          new_Game,
  input  logic          seed_load,
  input  logic [N-1:0]  seed,
  input  logic          run,
  input  logic          step,
  output logic [N-1:0]  pn,
  output logic          pn_valid,
  output logic          wrap,
  output logic          lockup,
  output logic [CW-1:0] period
);

  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  ref_seed_q, ref_seed_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          pn_valid_q, pn_valid_d;
  logic          wrap_q, wrap_d;
  logic          lockup_q, lockup_d;

  logic          adv;
  logic          seed_zero;
  logic [N-1:0]  seed_eff;
  logic          fb;
  logic [N-1:0]  next_state;

  assign adv        = run | step;
  assign seed_zero  = (seed == '0);
  assign seed_eff   = seed_zero ? DEFAULT_SEED : seed;
  assign fb         = ^(state_q & TAPS);
  assign next_state = {state_q[N-2:0], fb};

  always_comb begin
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    step_cnt_d = step_cnt_q;
    period_d   = period_q;
    pn_valid_d = 1'b0;
    wrap_d     = 1'b0;
    lockup_d   = 1'b0;
    if (seed_load) begin
      // A load swallows any concurrent advance request.
      state_d    = seed_eff;
      ref_seed_d = seed_eff;
      step_cnt_d = '0;
      lockup_d   = seed_zero;
    end else if (adv) begin
      state_d    = next_state;
      pn_valid_d = 1'b1;
      if (next_state == ref_seed_q) begin
        wrap_d     = 1'b1;
        period_d   = step_cnt_q + CW'(1);
        step_cnt_d = '0;
      end else if (step_cnt_q != '1) begin
        step_cnt_d = step_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge new_Game) begin
    if (new_Game) begin
      state_q    <= DEFAULT_SEED;
      ref_seed_q <= DEFAULT_SEED;
      step_cnt_q <= '0;
      period_q   <= '0;
      pn_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      pn_valid_q <= pn_valid_d;
      wrap_q     <= wrap_d;
      lockup_q   <= lockup_d;
    end
  end

  assign pn       = state_q;
  assign pn_valid = pn_valid_q;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;
  assign period   = period_q;

endmodule

// File: tb/tb_pn_gen.sv
// Directed bench for pn_gen: default 6-bit instance against a scoreboard, plus a 4-bit/CW=3 instance for counter saturation.
module tb_pn_gen;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        new_Game, seed_load, run, step;
  logic [5:0]  seed;
  logic [5:0]  pn;
  logic        pn_valid, wrap, lockup;
  logic [15:0] period;

  logic        seed_load4, run4, step4;
  logic [3:0]  seed4;
  logic [3:0]  pn4;
  logic        pn_valid4, wrap4, lockup4;
  logic [2:0]  period4;

  pn_gen dut (
    .clock(clock), .new_Game(new_Game), .seed_load(seed_load), .seed(seed),
    .run(run), .step(step), .pn(pn), .pn_valid(pn_valid), .wrap(wrap),
    .lockup(lockup), .period(period)
  );

  pn_gen #(.N(4), .TAPS(4'b1100), .DEFAULT_SEED(4'b0001), .CW(3)) dut4 (
    .clock(clock), .new_Game(new_Game), .seed_load(seed_load4), .seed(seed4),
    .run(run4), .step(step4), .pn(pn4), .pn_valid(pn_valid4), .wrap(wrap4),
    .lockup(lockup4), .period(period4)
  );

  typedef struct packed {
    logic [5:0]  pn;
    logic        v;
    logic        w;
    logic        l;
    logic [15:0] period;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [5:0]  m_state;
  logic [5:0]  m_ref;
  logic [15:0] m_cnt;
  logic [15:0] m_period;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] nx6(input logic [5:0] s);
    logic [5:0] t;
    t = s & 6'b110000;
    return {s[4:0], ^t};
  endfunction

  task automatic model_reset();
    m_state  = 6'd1;
    m_ref    = 6'd1;
    m_cnt    = '0;
    m_period = '0;
    sb.delete();
  endtask

  // Drive one cycle on the 6-bit instance, predict, then compare after the edge.
  task automatic cyc(input logic ld, input logic [5:0] sd, input logic r, input logic st);
    exp_t e;
    @(negedge clock);
    seed_load = ld; seed = sd; run = r; step = st;
    e = '0;
    if (ld) begin
      m_state = (sd == 6'd0) ? 6'd1 : sd;
      m_ref   = m_state;
      m_cnt   = '0;
      e.l     = (sd == 6'd0);
    end else if (r | st) begin
      m_state = nx6(m_state);
      e.v     = 1'b1;
      if (m_state == m_ref) begin
        e.w      = 1'b1;
        m_period = m_cnt + 16'd1;
        m_cnt    = '0;
      end else if (m_cnt != 16'hffff) begin
        m_cnt = m_cnt + 16'd1;
      end
    end
    e.pn     = m_state;
    e.period = m_period;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: observed size 0 expected >0");
    end else begin
      e = sb.pop_front();
      check("pn", 32'(pn), 32'(e.pn));
      check("pn_valid", 32'(pn_valid), 32'(e.v));
      check("wrap", 32'(wrap), 32'(e.w));
      check("lockup", 32'(lockup), 32'(e.l));
      check("period", 32'(period), 32'(e.period));
    end
  endtask

  initial begin
    int   wraps;
    int   distinct;
    int   vcount;
    logic seen [64];

    new_Game = 1'b1; seed_load = 1'b0; seed = '0; run = 1'b0; step = 1'b0;
    seed_load4 = 1'b0; seed4 = '0; run4 = 1'b0; step4 = 1'b0;
    model_reset();
    #3;
    check("rst_pn", 32'(pn), 32'h1);
    check("rst_period", 32'(period), 32'h0);
    check("rst_flags", {29'd0, pn_valid, wrap, lockup}, 32'h0);
    check("rst_pn4", 32'(pn4), 32'h1);
    @(posedge clock);
    @(negedge clock);
    new_Game = 1'b0;

    // Full 63-step cycle from reset.
    wraps = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      cyc(1'b0, 6'd0, 1'b1, 1'b0);
      seen[pn] = 1'b1;
      if (wrap) wraps++;
      if (i == 1)  check("seq_step1", 32'(pn), 32'b000010);
      if (i == 4)  check("seq_step4", 32'(pn), 32'b010000);
      if (i == 5)  check("seq_step5", 32'(pn), 32'b100001);
      if (i == 62) check("no_wrap_early", 32'(wraps), 32'd0);
    end
    distinct = 0;
    for (int i = 0; i < 64; i++) if (seen[i]) distinct++;
    check("wrap_count", 32'(wraps), 32'd1);
    check("period63", 32'(period), 32'd63);
    check("pn_after_wrap", 32'(pn), 32'd1);
    check("distinct63", 32'(distinct), 32'd63);
    check("zero_unseen", 32'(seen[0]), 32'd0);

    // Zero-seed load mid-sequence: lockup pulse, counter cleared.
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 1'b1, 1'b0);
    cyc(1'b1, 6'd0, 1'b0, 1'b0);
    check("lock_pn", 32'(pn), 32'd1);
    check("lock_pulse", 32'(lockup), 32'd1);
    cyc(1'b0, 6'd0, 1'b0, 1'b0);
    check("lock_clear", 32'(lockup), 32'd0);
    for (int i = 0; i < 63; i++) cyc(1'b0, 6'd0, 1'b1, 1'b0);
    check("period_after_load", 32'(period), 32'd63);

    // Load beats run.
    cyc(1'b1, 6'b101010, 1'b1, 1'b0);
    check("ld_run_pn", 32'(pn), 32'b101010);
    check("ld_run_valid", 32'(pn_valid), 32'd0);
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    check("ld_run_next", 32'(pn), 32'b010101);

    // Single-stepping with gaps, then step+run together.
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 6'd0, 1'b0, (i % 2) == 0);
      if (pn_valid) vcount++;
    end
    check("step_pulses", 32'(vcount), 32'd3);
    cyc(1'b0, 6'd0, 1'b1, 1'b1);
    check("step_run_once", 32'(pn), 32'(nx6(nx6(nx6(nx6(6'b010101))))));

    // Asynchronous reset between edges while running.
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    @(posedge clock);
    #3;
    new_Game = 1'b1;
    #1;
    check("arst_pn", 32'(pn), 32'd1);
    check("arst_period", 32'(period), 32'd0);
    check("arst_flags", {29'd0, pn_valid, wrap, lockup}, 32'h0);
    @(posedge clock);
    #1;
    check("arst_hold_pn", 32'(pn), 32'd1);
    check("arst_hold_valid", 32'(pn_valid), 32'd0);
    @(negedge clock);
    new_Game = 1'b0; run = 1'b0;
    model_reset();
    cyc(1'b0, 6'd0, 1'b1, 1'b0);
    check("post_rst_first", 32'(pn), 32'b000010);

    // 4-bit instance: 15-step period through a saturating 3-bit counter.
    @(negedge clock);
    run = 1'b0;
    seed_load4 = 1'b1; seed4 = 4'b0001;
    @(negedge clock);
    seed_load4 = 1'b0; run4 = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      if (wrap4) wraps++;
      if (i == 14) check("n4_no_early_wrap", 32'(wraps), 32'd0);
      if (i == 15) check("n4_wrap_at_15", 32'(wrap4), 32'd1);
    end
    @(negedge clock);
    run4 = 1'b0;
    check("n4_period_trunc", 32'(period4), 32'd0);
    check("n4_pn_ref", 32'(pn4), 32'd1);
    check("n4_wrap_count", 32'(wraps), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pn_gen.md
PN_GEN -- requirements
Module: pn_gen

Interface
REQ-001 Parameter N, default 6: LFSR width, legal range 3..32.
REQ-002 Parameter TAPS, default 6'b110000: feedback mask. Bit i set means state bit i enters the feedback XOR.
REQ-003 Parameter DEFAULT_SEED, default 1: nonzero state used after reset and as a substitute for a zero seed.
REQ-004 Parameter CW, default 16: width of the step counter and the period register.
REQ-005 Port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port new_Game, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port seed_load, input, 1 bit: synchronous load of seed.
REQ-008 Port seed, input, N bits: load value.
REQ-009 Port run, input, 1 bit: free-run enable; advance one step every cycle while high.
REQ-010 Port step, input, 1 bit: single-step request; advance one step in a cycle where it is high.
REQ-011 Port pn, output, N bits: current LFSR state (registered).
REQ-012 Port pn_valid, output, 1 bit: one-cycle pulse; pn holds a freshly advanced value.
REQ-013 Port wrap, output, 1 bit: one-cycle pulse; the sequence has returned to the reference seed.
REQ-014 Port lockup, output, 1 bit: one-cycle pulse; a zero seed was replaced by DEFAULT_SEED.
REQ-015 Port period, output, CW bits: step count captured at the last wrap.

Function
REQ-016 Feedback: fb = XOR-reduce(state & TAPS).
REQ-017 Next state: {state[N-2:0], fb}.
REQ-018 adv = run | step. Both high in the same cycle give exactly one step.
REQ-019 Priority: seed_load beats adv. When both are high, the load takes effect and no step occurs that cycle.
REQ-020 Load: state, pn and ref_seed <= seed, step_cnt <= 0, pn_valid = 0, wrap = 0.
REQ-021 Load with seed == 0: DEFAULT_SEED is used in place of seed everywhere in REQ-020, and lockup pulses high in the next cycle.
REQ-022 Advance: state and pn <= next state on the same edge (zero-cycle lag; pn always equals state), and pn_valid = 1 for that one cycle.
REQ-023 Advance when next state == ref_seed: wrap = 1 for one cycle, period <= step_cnt + 1, step_cnt <= 0.
REQ-024 Advance without a match: step_cnt <= step_cnt + 1, saturating at all-ones (no wrap-around).
REQ-025 Idle (no load, no adv): state, pn, step_cnt and period hold; pn_valid, wrap and lockup are 0.
REQ-026 period is not cleared by a load; it holds until the next wrap.
REQ-027 An all-zero state is unreachable: it is prevented at reset and at load, and TAPS includes bit N-1.
REQ-028 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-029 While new_Game is high, regardless of clock: state = pn = ref_seed = DEFAULT_SEED, step_cnt = 0, period = 0, pn_valid = wrap = lockup = 0.
REQ-030 Reset asserted mid-run overrides everything. After release, the first clock edge with adv high produces the successor of DEFAULT_SEED.

Verification
REQ-031 Reset, then run=1 for 63 cycles (N=6, defaults): pn sequence 000001 -> 000010 -> ... -> 010000 -> 100001 ...; wrap pulses on the 63rd advance; period = 63; pn = 000001; all 63 nonzero values seen exactly once.
REQ-032 seed_load with seed = 0: next cycle pn = 000001, lockup = 1 for one cycle, step_cnt = 0.
REQ-033 seed_load = 1 together with run = 1, seed = 101010: pn = 101010 with no step; pn_valid = 0 that cycle; the following run cycle gives 010101.
REQ-034 run = 0, step pulsed 3 times with idle gaps: exactly 3 advances, pn_valid pulses 3 times, pn holds in the gaps; step and run high together give a single advance.
REQ-035 new_Game asserted asynchronously mid-run (between clock edges): pn = 000001 immediately; period = 0; no wrap or pn_valid pulse until the next advance.
REQ-036 N = 4, TAPS = 4'b1100, CW = 3, seed 0001, run = 1: wrap after 15 steps; the step_cnt saturation path is exercised by checking the counter holds at 7 and period captures 7+1 wraps to 0 correctly (width-truncated to CW), with no counter wrap-around before the wrap event.
